collatz_datapath: RTL and testbench

COLLATZ_DATAPATH -- requirements
Module: collatz_datapath

---
 rtl/collatz_pkg.sv | 13 +
 rtl/collatz_alu.sv | 34 +++
 rtl/collatz_datapath.sv | 96 +++++++++
 tb/tb_collatz_datapath.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/collatz_pkg.sv
// Shared constants for the Collatz datapath and its controller.
// Holds the ALU function-select encoding and the default data width.
package collatz_pkg;

  localparam int COLLATZ_WIDTH = 16;
  localparam int COLLATZ_STEP_W = 16;

  localparam logic [1:0] FS_HOLD = 2'b00;
  localparam logic [1:0] FS_ADD  = 2'b01;
  localparam logic [1:0] FS_SHR  = 2'b10;
  localparam logic [1:0] FS_DBL  = 2'b11;

endpackage

// File: rtl/collatz_alu.sv
// Combinational ALU: hold, X+T+1, logical X>>1, hold (T-write cycle).
// Ports: x_i, t_i operands; fs_i select; res_o result; carry_o add carry-out.
module collatz_alu
  import collatz_pkg::*;
#(
  parameter int WIDTH = COLLATZ_WIDTH
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] t_i,
  input  logic [1:0]       fs_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, x_i} + {1'b0, t_i}
             + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    res_o   = x_i;
    carry_o = 1'b0;
    unique case (fs_i)
      FS_HOLD: res_o = x_i;
      FS_ADD: begin
        res_o   = sum[WIDTH-1:0];
        carry_o = sum[WIDTH];
      end
      FS_SHR:  res_o = x_i >> 1;
      FS_DBL:  res_o = x_i;
    endcase
  end

endmodule

// File: rtl/collatz_datapath.sv
// Collatz datapath: working reg X, shadow reg T (2X), sticky ovf, steps.
// Ports: clk, reset_n (async low), din, sel, wen, fs1/fs0 in;
// one, x0, x, ovf, steps out. COLLATZ_STEP_CNT_EN enables the counter.
module collatz_datapath
  import collatz_pkg::*;
#(
  parameter int WIDTH  = COLLATZ_WIDTH,
  parameter int STEP_W = COLLATZ_STEP_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  din,
  input  logic              sel,
  input  logic              wen,
  input  logic              fs1,
  input  logic              fs0,
  output logic              one,
  output logic              x0,
  output logic [WIDTH-1:0]  x,
  output logic              ovf,
  output logic [STEP_W-1:0] steps
);

  logic [1:0]       fs;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  assign fs  = {fs1, fs0};
  assign src = sel ? x_q : din;

  collatz_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .x_i    (x_q),
    .t_i    (t_q),
    .fs_i   (fs),
    .res_o  (alu_res),
    .carry_o(alu_carry)
  );

  // A din load clears ovf first; a T write of the same edge
  // may still set it again when it shifts out a 1.
  always_comb begin
    x_d   = sel ? alu_res : din;
    t_d   = wen ? (src << 1) : t_q;
    ovf_d = (sel & ovf_q)
          | (sel & alu_carry)
          | (wen & src[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q   <= '0;
      t_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      t_q   <= t_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef COLLATZ_STEP_CNT_EN
  logic [STEP_W-1:0] steps_q, steps_d;

  always_comb begin
    steps_d = steps_q;
    if (!sel)
      steps_d = '0;
    else if ((fs == FS_ADD || fs == FS_SHR)
             && steps_q != '1)
      steps_d = steps_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      steps_q <= '0;
    else
      steps_q <= steps_d;
  end

  assign steps = steps_q;
`else
  assign steps = '0;
`endif

  assign x   = x_q;
  assign x0  = x_q[0];
  assign one = (x_q == WIDTH'(1));
  assign ovf = ovf_q;

endmodule

// File: tb/tb_collatz_datapath.sv
// Self-checking bench for collatz_datapath against a Collatz model.
// Builds with or without COLLATZ_STEP_CNT_EN.
module tb_collatz_datapath;

`ifdef COLLATZ_STEP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [15:0] din;
  logic        sel;
  logic        wen;
  logic        fs1;
  logic        fs0;
  logic        one;
  logic        x0;
  logic [15:0] x;
  logic        ovf;
  logic [15:0] steps;

  int checks;
  int failures;

  collatz_datapath dut (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (din),
    .sel    (sel),
    .wen    (wen),
    .fs1    (fs1),
    .fs0    (fs0),
    .one    (one),
    .x0     (x0),
    .x      (x),
    .ovf    (ovf),
    .steps  (steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_steps(input int n);
    return CNT_EN ? n : 0;
  endfunction

  task automatic drive(input logic s, input logic w,
                       input logic [1:0] f,
                       input logic [15:0] d);
    @(negedge clk);
    sel = s;
    wen = w;
    {fs1, fs0} = f;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    sel = 1'b0; wen = 1'b0;
    fs1 = 1'b0; fs0 = 1'b0; din = 16'd9;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (x !== 16'd0 || ovf !== 1'b0 || one !== 1'b0
        || x0 !== 1'b0 || steps !== 16'd0) begin
      failures++;
      $display("FAIL reset: x=%0d ovf=%b one=%b x0=%b steps=%0d want all 0",
               x, ovf, one, x0, steps);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_load_one;
    drive(1'b0, 1'b0, 2'b00, 16'd1);
    checks++;
    if (x !== 16'd1 || one !== 1'b1 || x0 !== 1'b1
        || steps !== 16'd0) begin
      failures++;
      $display("FAIL load_one: x=%0d one=%b x0=%b steps=%0d want 1 1 1 0",
               x, one, x0, steps);
    end
  endtask

  task automatic test_run6;
    int path[9] = '{6, 3, 10, 5, 16, 8, 4, 2, 1};
    int idx;
    int cur;
    idx = 1;
    cur = 6;
    drive(1'b0, 1'b0, 2'b00, 16'd6);
    checks++;
    if (x !== 16'd6) begin
      failures++;
      $display("FAIL run6_load: x=%0d want 6", x);
    end
    while (cur != 1 && idx < 9) begin
      if (cur % 2 == 1) begin
        drive(1'b1, 1'b1, 2'b11, 16'd0);
        drive(1'b1, 1'b0, 2'b01, 16'd0);
        checks++;
        if (x !== 16'(path[idx])) begin
          failures++;
          $display("FAIL run6_path[%0d]: x=%0d want %0d",
                   idx, x, path[idx]);
        end
        idx++;
      end
      drive(1'b1, 1'b0, 2'b10, 16'd0);
      checks++;
      if (x !== 16'(path[idx])) begin
        failures++;
        $display("FAIL run6_path[%0d]: x=%0d want %0d",
                 idx, x, path[idx]);
      end
      cur = path[idx];
      idx++;
    end
    checks++;
    if (one !== 1'b1 || steps !== 16'(exp_steps(8))) begin
      failures++;
      $display("FAIL run6_end: one=%b steps=%0d want 1 %0d",
               one, steps, exp_steps(8));
    end
  endtask

  // Controller plus abstract model: odd -> 3n+1 then /2, even -> /2.
  // Arithmetic is done wide and truncated to 16 bits, flagging ovf.
  task automatic run_collatz(input int n, input string nm,
                             output int ops_o, output bit movf_o,
                             output int mx_o);
    int mx;
    int ops;
    int t;
    int s;
    bit movf;
    mx = n;
    ops = 0;
    movf = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 16'(n));
    while (mx != 1 && ops < 400) begin
      if (mx % 2 == 1) begin
        t = 2 * mx;
        if (t > 65535) movf = 1'b1;
        t = t % 65536;
        s = mx + t + 1;
        if (s > 65535) movf = 1'b1;
        mx = s % 65536;
        drive(1'b1, 1'b1, 2'b11, 16'd0);
        drive(1'b1, 1'b0, 2'b01, 16'd0);
        ops++;
        checks++;
        if (x !== 16'(mx)) begin
          failures++;
          $display("FAIL %s_add: n=%0d x=%0d want %0d", nm, n, x, mx);
        end
      end
      mx = mx / 2;
      drive(1'b1, 1'b0, 2'b10, 16'd0);
      ops++;
      checks++;
      if (x !== 16'(mx)) begin
        failures++;
        $display("FAIL %s_shr: n=%0d x=%0d want %0d", nm, n, x, mx);
      end
    end
    ops_o = ops;
    movf_o = movf;
    mx_o = mx;
  endtask

  task automatic test_run7;
    int ops;
    bit movf;
    int mx;
    run_collatz(7, "run7", ops, movf, mx);
    checks++;
    if (one !== 1'b1 || ovf !== 1'b0
        || steps !== 16'(exp_steps(16))) begin
      failures++;
      $display("FAIL run7_end: one=%b ovf=%b steps=%0d want 1 0 %0d",
               one, ovf, steps, exp_steps(16));
    end
  endtask

  task automatic test_random;
    int ops;
    bit movf;
    int mx;
    int n;
    for (int i = 0; i < 8; i++) begin
      n = int'($urandom_range(2, 400));
      run_collatz(n, "rand", ops, movf, mx);
      checks++;
      if (one !== (mx == 1) || ovf !== movf
          || steps !== 16'(exp_steps(ops))) begin
        failures++;
        $display("FAIL rand_end: n=%0d one=%b ovf=%b steps=%0d want %b %b %0d",
                 n, one, ovf, steps, mx == 1, movf, exp_steps(ops));
      end
    end
  endtask

  task automatic test_ovf;
    drive(1'b0, 1'b0, 2'b00, 16'hFFFF);
    checks++;
    if (ovf !== 1'b0 || x !== 16'hFFFF) begin
      failures++;
      $display("FAIL ovf_load: ovf=%b x=%h want 0 ffff", ovf, x);
    end
    drive(1'b1, 1'b1, 2'b11, 16'd0);
    checks++;
    if (ovf !== 1'b1 || x !== 16'hFFFF) begin
      failures++;
      $display("FAIL ovf_wen: ovf=%b x=%h want 1 ffff", ovf, x);
    end
    drive(1'b1, 1'b0, 2'b00, 16'd0);
    drive(1'b1, 1'b0, 2'b00, 16'd0);
    checks++;
    if (ovf !== 1'b1 || x !== 16'hFFFF) begin
      failures++;
      $display("FAIL ovf_hold: ovf=%b x=%h want 1 ffff", ovf, x);
    end
    drive(1'b1, 1'b0, 2'b01, 16'd0);
    checks++;
    if (ovf !== 1'b1 || x !== 16'hFFFE) begin
      failures++;
      $display("FAIL ovf_add: ovf=%b x=%h want 1 fffe", ovf, x);
    end
    drive(1'b0, 1'b0, 2'b00, 16'd2);
    checks++;
    if (ovf !== 1'b0 || x !== 16'd2) begin
      failures++;
      $display("FAIL ovf_clear: ovf=%b x=%0d want 0 2", ovf, x);
    end
    // carry alone: T=2*0x8000 wraps to 0 silently? no: MSB drop sets ovf
    drive(1'b0, 1'b1, 2'b00, 16'h8000);
    checks++;
    if (ovf !== 1'b1 || x !== 16'h8000) begin
      failures++;
      $display("FAIL ovf_load_set: ovf=%b x=%h want 1 8000", ovf, x);
    end
    drive(1'b0, 1'b1, 2'b00, 16'h4000);
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_load_noset: ovf=%b want 0", ovf);
    end
    // X=0x4000, T=0x8000: add gives 0xC001, no carry-out
    drive(1'b1, 1'b0, 2'b01, 16'd0);
    checks++;
    if (ovf !== 1'b0 || x !== 16'hC001) begin
      failures++;
      $display("FAIL ovf_add_nocarry: ovf=%b x=%h want 0 c001", ovf, x);
    end
    // X=0xC001, T=0x8000: 0x14002 carries out
    drive(1'b1, 1'b0, 2'b01, 16'd0);
    checks++;
    if (ovf !== 1'b1 || x !== 16'h4002) begin
      failures++;
      $display("FAIL ovf_add_carry: ovf=%b x=%h want 1 4002", ovf, x);
    end
  endtask

  task automatic test_async_reset;
    drive(1'b0, 1'b0, 2'b00, 16'd10);
    drive(1'b1, 1'b1, 2'b11, 16'd0);
    drive(1'b1, 1'b0, 2'b01, 16'd0);
    checks++;
    if (x !== 16'd31 || steps !== 16'(exp_steps(1))) begin
      failures++;
      $display("FAIL areset_pre: x=%0d steps=%0d want 31 %0d",
               x, steps, exp_steps(1));
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (x !== 16'd0 || ovf !== 1'b0 || steps !== 16'd0
        || one !== 1'b0 || x0 !== 1'b0) begin
      failures++;
      $display("FAIL areset_now: x=%0d ovf=%b steps=%0d want 0 0 0",
               x, ovf, steps);
    end
    @(negedge clk);
    reset_n = 1'b1;
    sel = 1'b0; wen = 1'b0; din = 16'd3;
    @(posedge clk);
    #1;
    checks++;
    if (x !== 16'd3 || x0 !== 1'b1 || one !== 1'b0) begin
      failures++;
      $display("FAIL areset_after: x=%0d x0=%b one=%b want 3 1 0",
               x, x0, one);
    end
  endtask

  task automatic test_hold;
    drive(1'b0, 1'b0, 2'b00, 16'd5);
    drive(1'b1, 1'b1, 2'b11, 16'd0);
    drive(1'b1, 1'b0, 2'b10, 16'd0);
    drive(1'b0, 1'b0, 2'b00, 16'd5);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 2'b00, 16'd0);
      checks++;
      if (x !== 16'd5 || steps !== 16'd0) begin
        failures++;
        $display("FAIL hold[%0d]: x=%0d steps=%0d want 5 0",
                 i, x, steps);
      end
    end
    // T was written as 10 before the reload; add proves it held
    drive(1'b1, 1'b0, 2'b01, 16'd0);
    checks++;
    if (x !== 16'd16 || steps !== 16'(exp_steps(1))) begin
      failures++;
      $display("FAIL hold_t: x=%0d steps=%0d want 16 %0d",
               x, steps, exp_steps(1));
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_load_one();
    test_run6();
    test_run7();
    test_ovf();
    test_async_reset();
    test_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
